// File: rtl/frame_stream_sink_if.sv
// Frame-in / sample-out bundle for the terminal sink of the effect chain.
// slave is the sink's view; master is the upstream stage plus DAC side.
interface frame_stream_sink_if #(
  parameter int FRAME_LEN = 32,
  parameter int SAMPLE_W  = 16,
  parameter int ADDR_W    = 32
);
  logic                               prev_module_done;
  logic [ADDR_W-1:0]                  address_in;
  logic [FRAME_LEN-1:0][SAMPLE_W-1:0] audio_in;
  logic                               ready_for_data;
  logic                               flush;
  logic [SAMPLE_W-1:0]                sample_out;
  logic                               sample_valid;
  logic                               sample_ready;
  logic                               frame_done;
  logic [ADDR_W-1:0]                  frame_addr;
  logic [15:0]                        underrun_count;

  modport slave (
    input  prev_module_done, address_in, audio_in, flush, sample_ready,
    output ready_for_data, sample_out, sample_valid, frame_done, frame_addr, underrun_count
  );

  modport master (
    output prev_module_done, address_in, audio_in, flush, sample_ready,
    input  ready_for_data, sample_out, sample_valid, frame_done, frame_addr, underrun_count
  );
endinterface

// File: rtl/frame_stream_sink.sv
// Ping-pong frame buffer serialising whole frames to a valid/ready sample port.
// Sample[0] valid the cycle after frame accept; ready_for_data drops while both banks are held.
module frame_stream_sink #(
  parameter int FRAME_LEN = 32,
  parameter int SAMPLE_W  = 16,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  frame_stream_sink_if.slave   bus
);
  localparam int                IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {S_EMPTY, S_STREAM} state_e;
  typedef logic [FRAME_LEN-1:0][SAMPLE_W-1:0] frame_t;

  state_e             state_q, state_d;
  logic [1:0]         frames_held_q, frames_held_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               primed_q, primed_d;
  logic               frame_done_q, frame_done_d;
  logic [ADDR_W-1:0]  frame_addr_q, frame_addr_d;
  logic [15:0]        underrun_q, underrun_d;
  frame_t             bank_q [2];
  frame_t             bank_d [2];
  logic [ADDR_W-1:0]  baddr_q [2];
  logic [ADDR_W-1:0]  baddr_d [2];

  logic ready_int;
  logic valid_int;
  logic accept;
  logic take;
  logic last_take;

  assign ready_int = (frames_held_q < 2'd2);
  assign valid_int = (state_q == S_STREAM);

  assign bus.ready_for_data = ready_int;
  assign bus.sample_valid   = valid_int;
  assign bus.sample_out     = valid_int ? bank_q[rd_bank_q][idx_q] : '0;
  assign bus.frame_done     = frame_done_q;
  assign bus.frame_addr     = frame_addr_q;
  assign bus.underrun_count = underrun_q;

  always_comb begin
    state_d       = state_q;
    frames_held_d = frames_held_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    idx_d         = idx_q;
    primed_d      = primed_q;
    frame_done_d  = 1'b0;
    frame_addr_d  = frame_addr_q;
    underrun_d    = underrun_q;
    bank_d        = bank_q;
    baddr_d       = baddr_q;

    accept    = bus.prev_module_done && ready_int && !bus.flush;
    take      = valid_int && bus.sample_ready;
    last_take = take && (idx_q == LAST_IDX);

    if (accept) begin
      bank_d[wr_bank_q]  = bus.audio_in;
      baddr_d[wr_bank_q] = bus.address_in;
      wr_bank_d          = ~wr_bank_q;
      primed_d           = 1'b1;
    end

    if (take) begin
      idx_d = last_take ? '0 : idx_q + IDX_W'(1);
    end

    if (last_take) begin
      rd_bank_d    = ~rd_bank_q;
      frame_done_d = 1'b1;
      frame_addr_d = baddr_q[rd_bank_q];
    end

    // Accept and release in the same cycle cancel, so the other bank streams without a bubble.
    frames_held_d = frames_held_q + {1'b0, accept} - {1'b0, last_take};

    if (primed_q && bus.sample_ready && !valid_int && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end

    if (bus.flush) begin
      frames_held_d = '0;
      idx_d         = '0;
      rd_bank_d     = 1'b0;
      wr_bank_d     = 1'b0;
      frame_done_d  = 1'b0;
      frame_addr_d  = frame_addr_q;
    end

    state_d = (frames_held_d != 2'd0) ? S_STREAM : S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_EMPTY;
      frames_held_q <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      idx_q         <= '0;
      primed_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_addr_q  <= '0;
      underrun_q    <= '0;
    end else begin
      state_q       <= state_d;
      frames_held_q <= frames_held_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      idx_q         <= idx_d;
      primed_q      <= primed_d;
      frame_done_q  <= frame_done_d;
      frame_addr_q  <= frame_addr_d;
      underrun_q    <= underrun_d;
    end
  end

  // Sample storage carries no reset; it is only read while a frame is held.
  always_ff @(posedge clk) begin
    bank_q  <= bank_d;
    baddr_q <= baddr_d;
  end
endmodule
